soc_system_pcp_0_cpu_0_mul_seq: RTL and testbench
=================================================

# soc_system_pcp_0_cpu_0_mul_seq

Multiply sequencer for the PCP Nios II core. It sits between the A-stage issue logic and the 32×32 low-word multiplier cell (`soc_system_pcp_0_cpu_0_mult_cell`).

- MUL (low 32 bits): operands are registered into the cell's source ports, and the cell's result is captured after its one-cycle internal register.
- MULXUU, MULXSU and MULXSS (high 32 bits of the 64-bit product): computed locally by a four-pass 16×16 partial-product accumulator, with sign correction at the end.

It presents a start/busy/done handshake to the pipeline.

## Interface
Parameters: none (widths fixed at 32).

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- A_mul_start  in  1  one-cycle request; sampled only when not busy.
- A_mul_op  in  2  operation: 00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS.
- A_mul_a  in  32  operand a; sampled with start.
- A_mul_b  in  32  operand b; sampled with start.
- A_mul_src1  out  32  registered operand a, driven to the mult cell.
- A_mul_src2  out  32  registered operand b, driven to the mult cell.
- A_mul_cell_result  in  32  low-word product returned by the mult cell.
- A_mul_busy  out  1  operation in flight; start is ignored while high.
- A_mul_done  out  1  one-cycle pulse; result valid in the same cycle.
- A_mul_result  out  32  final result; holds its value until the next done.

## Operation
- States: IDLE, LOWW, LOWC, PP0, PP1, PP2, PP3, FIX.
- In IDLE, `A_mul_start`=1 latches the op and operands.
  - MUL: `A_mul_src1`/`A_mul_src2` ← a/b; next state LOWW.
  - Any other op: the internal magnitudes ma/mb, sign flag s and 64-bit accumulator acc=0 are loaded; next state PP0.
- MUL path:
  - LOWW is a wait cycle for the cell's internal register; next state LOWC.
  - LOWC: `A_mul_result` ← `A_mul_cell_result`, done set, next state IDLE.
- Signedness of the high ops:
  - MULXSS: both operands are signed.
  - MULXSU: a is signed, b is unsigned.
  - MULXUU: both operands are unsigned.
  - ma = |a| if a is signed and a[31]=1, else a; mb likewise.
  - s = (a signed & a[31]) XOR (b signed & b[31]).
  - |0x80000000| = 0x80000000 (unsigned 32-bit, no overflow).
- Partial products, all 16×16 unsigned → 32 bits, zero-extended to 64 bits, one per state:
  - PP0: acc += ma[15:0]·mb[15:0].
  - PP1: acc += ma[31:16]·mb[15:0] << 16.
  - PP2: acc += ma[15:0]·mb[31:16] << 16.
  - PP3: acc += ma[31:16]·mb[31:16] << 32.
  - Accumulator arithmetic is modulo 2^64; no carry is lost because the full unsigned product is < 2^64.
- FIX:
  - `A_mul_result` ← (s ? (~acc+1) : acc)[63:32].
  - done set; next state IDLE.
- Only one 16×16 multiplier is instantiated inside the block, muxed by state.
- `A_mul_src1`/`A_mul_src2` change only on MUL acceptance or reset. High ops leave them unchanged.

## Timing
- Reset values: `A_mul_src1`=0, `A_mul_src2`=0, `A_mul_busy`=0, `A_mul_done`=0, `A_mul_result`=0, state IDLE, acc=0.
- Reset in any state returns the block to IDLE on the next edge. The in-flight operation is discarded and no done pulse is produced.
- Start sampled high in cycle t:
  - MUL: busy is high in cycles t+1..t+2; done is high in cycle t+3.
  - High ops: busy is high in cycles t+1..t+5; done is high in cycle t+6.
- `A_mul_busy` is registered and equals (state≠IDLE). `A_mul_done` is registered and is high for exactly one cycle.
- Start while busy is ignored. Operands and op are not re-sampled.
- Start in the done cycle is accepted, because busy is low then. Back-to-back throughput:
  - MUL: one result per 3 cycles.
  - High ops: one result per 6 cycles.
- `A_mul_result` changes only in the cycle of a done pulse, or on reset.
- The operand inputs need to be valid only in the start cycle.

## Test plan
- MUL with a=0xFFFFFFFF, b=0xFFFFFFFF, start in cycle t:
  - `A_mul_src1`/`A_mul_src2` are 0xFFFFFFFF from t+1.
  - done is high in t+3 with result 0x00000001.
  - busy is high in t+1..t+2.
- MULXUU with 0xFFFFFFFF × 0xFFFFFFFF:
  - done in t+6, result 0xFFFFFFFE.
  - The src ports keep their previous value.
- MULXSS cases:
  - 0x80000000 × 0x80000000 → 0x40000000.
  - 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
  - 0x00000000 × 0x80000000 → 0x00000000.
- MULXSU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULXSU with 0x7FFFFFFF × 0xFFFFFFFF → 0x7FFFFFFE.
- Start pulses in t+2..t+4 during a high op are ignored: exactly one done, in t+6.
  - A new MUL started in the t+6 done cycle gives done in t+9.
- Reset asserted during PP2:
  - All outputs are 0 on the next cycle and no done follows.
  - The next start behaves normally.

Source files
------------

// File: rtl/soc_system_pcp_0_cpu_0_mul_seq.sv
// Multiply sequencer for the PCP Nios II core.
// MUL goes through the external low-word mult cell (one internal register stage);
// MULXUU/MULXSU/MULXSS are built locally from four 16x16 partial products
// accumulated into a 64-bit register, with a final sign correction.
module soc_system_pcp_0_cpu_0_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        A_mul_start,
  input  logic [1:0]  A_mul_op,
  input  logic [31:0] A_mul_a,
  input  logic [31:0] A_mul_b,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result,
  output logic        A_mul_busy,
  output logic        A_mul_done,
  output logic [31:0] A_mul_result
);

  typedef enum logic [2:0] {
    StIdle, StLowW, StLowC, StPp0, StPp1, StPp2, StPp3, StFix
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic        sign_q, sign_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Operand conditioning at acceptance: op[1] marks a signed, op==11 marks b signed.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = A_mul_op[1] & A_mul_a[31];
  assign b_neg = (A_mul_op == 2'b11) & A_mul_b[31];
  // |0x80000000| wraps to itself, which is the correct unsigned magnitude.
  assign a_mag = a_neg ? (~A_mul_a + 32'd1) : A_mul_a;
  assign b_mag = b_neg ? (~A_mul_b + 32'd1) : A_mul_b;

  // Single shared 16x16 multiplier; operand halves and shift chosen by state.
  logic [15:0] pp_a, pp_b;
  logic [31:0] pp_prod;
  logic [5:0]  pp_shift;
  logic [63:0] pp_term;

  // Partial-product operand selection.
  always_comb begin
    pp_a     = ma_q[15:0];
    pp_b     = mb_q[15:0];
    pp_shift = 6'd0;
    case (state_q)
      StPp1: begin pp_a = ma_q[31:16]; pp_b = mb_q[15:0];  pp_shift = 6'd16; end
      StPp2: begin pp_a = ma_q[15:0];  pp_b = mb_q[31:16]; pp_shift = 6'd16; end
      StPp3: begin pp_a = ma_q[31:16]; pp_b = mb_q[31:16]; pp_shift = 6'd32; end
      default: ;
    endcase
  end

  assign pp_prod = pp_a * pp_b;
  assign pp_term = {32'd0, pp_prod} << pp_shift;

  // High word of the sign-corrected product: carry from -low only when low is zero.
  logic [31:0] fix_hi;
  assign fix_hi = sign_q ? (~acc_q[63:32] + {31'd0, (acc_q[31:0] == 32'd0)}) : acc_q[63:32];

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (A_mul_start) begin
          if (A_mul_op == 2'b00) begin
            src1_d  = A_mul_a;
            src2_d  = A_mul_b;
            state_d = StLowW;
          end else begin
            ma_d    = a_mag;
            mb_d    = b_mag;
            sign_d  = a_neg ^ b_neg;
            acc_d   = 64'd0;
            state_d = StPp0;
          end
        end
      end
      StLowW: state_d = StLowC;
      StLowC: begin
        result_d = A_mul_cell_result;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      StPp0: begin acc_d = acc_q + pp_term; state_d = StPp1; end
      StPp1: begin acc_d = acc_q + pp_term; state_d = StPp2; end
      StPp2: begin acc_d = acc_q + pp_term; state_d = StPp3; end
      StPp3: begin acc_d = acc_q + pp_term; state_d = StFix; end
      StFix: begin
        result_d = fix_hi;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      src1_q   <= 32'd0;
      src2_q   <= 32'd0;
      ma_q     <= 32'd0;
      mb_q     <= 32'd0;
      sign_q   <= 1'b0;
      acc_q    <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign A_mul_src1   = src1_q;
  assign A_mul_src2   = src2_q;
  assign A_mul_busy   = busy_q;
  assign A_mul_done   = done_q;
  assign A_mul_result = result_q;

endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_mul_seq.sv
// Scoreboard bench for the multiply sequencer, with a behavioural mult cell.
module tb_soc_system_pcp_0_cpu_0_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        A_mul_start = 1'b0;
  logic [1:0]  A_mul_op = 2'b00;
  logic [31:0] A_mul_a = 32'd0;
  logic [31:0] A_mul_b = 32'd0;
  logic [31:0] A_mul_src1, A_mul_src2;
  logic [31:0] A_mul_cell_result = 32'd0;
  logic        A_mul_busy, A_mul_done;
  logic [31:0] A_mul_result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  soc_system_pcp_0_cpu_0_mul_seq dut (
    .clk               (clk),
    .reset             (reset),
    .A_mul_start       (A_mul_start),
    .A_mul_op          (A_mul_op),
    .A_mul_a           (A_mul_a),
    .A_mul_b           (A_mul_b),
    .A_mul_src1        (A_mul_src1),
    .A_mul_src2        (A_mul_src2),
    .A_mul_cell_result (A_mul_cell_result),
    .A_mul_busy        (A_mul_busy),
    .A_mul_done        (A_mul_done),
    .A_mul_result      (A_mul_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mult cell: registered low word of src1*src2.
  always @(posedge clk) A_mul_cell_result <= A_mul_src1 * A_mul_src2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference via sign/zero extension to 64 bits.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'd0, a};
    bx = (op == 2'b11 && b[31]) ? {32'hFFFF_FFFF, b} : {32'd0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle start; returns at the negedge of cycle t+1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input bit track);
    exp_t e;
    A_mul_start = 1'b1;
    A_mul_op    = op;
    A_mul_a     = a;
    A_mul_b     = b;
    if (track) begin
      e.res = want;
      e.cyc = cyc + ((op == 2'b00) ? 3 : 6);
      sb.push_back(e);
    end
    @(negedge clk);
    A_mul_start = 1'b0;
    A_mul_op    = 2'($urandom_range(0, 3));
    A_mul_a     = $urandom();
    A_mul_b     = $urandom();
  endtask

  // Issue and return in the done cycle, so the next issue is back-to-back.
  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] want);
    issue(op, a, b, want, 1'b1);
    tick((op == 2'b00) ? 2 : 5);
  endtask

  // Result monitor.
  always @(negedge clk) begin
    if (A_mul_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", A_mul_result, mon_e.res);
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    tick(2);
    chk("rst_src1", A_mul_src1, 32'd0);
    chk("rst_src2", A_mul_src2, 32'd0);
    chk("rst_busy", 32'(A_mul_busy), 32'd0);
    chk("rst_done", 32'(A_mul_done), 32'd0);
    chk("rst_result", A_mul_result, 32'd0);
    reset = 1'b0;
    tick(1);

    // MUL FFFFFFFF x FFFFFFFF with cycle-by-cycle handshake.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    chk("mul_src1", A_mul_src1, 32'hFFFF_FFFF);
    chk("mul_src2", A_mul_src2, 32'hFFFF_FFFF);
    chk("mul_busy_t1", 32'(A_mul_busy), 32'd1);
    tick(1);
    chk("mul_busy_t2", 32'(A_mul_busy), 32'd1);
    chk("mul_nodone_t2", 32'(A_mul_done), 32'd0);
    tick(1);
    chk("mul_busy_t3", 32'(A_mul_busy), 32'd0);
    chk("mul_done_t3", 32'(A_mul_done), 32'd1);

    // Back-to-back MUL so the src ports hold a distinctive value.
    go(2'b00, 32'd3, 32'd5, 32'd15);

    // MULXUU: busy t+1..t+5, src ports untouched.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      chk("xuu_busy", 32'(A_mul_busy), 32'd1);
      chk("xuu_src1", A_mul_src1, 32'd3);
      chk("xuu_src2", A_mul_src2, 32'd5);
      if (i < 5) tick(1);
    end
    tick(1);
    chk("xuu_idle", 32'(A_mul_busy), 32'd0);

    go(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    go(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    go(2'b11, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    go(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    go(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE);

    // Starts held in t+2..t+4 must be ignored.
    issue(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b10, 32'h1234_5678, 32'h9ABC_DEF0),
          1'b1);
    tick(1);
    A_mul_start = 1'b1;
    A_mul_op    = 2'b00;
    A_mul_a     = 32'd1;
    A_mul_b     = 32'd1;
    tick(3);
    A_mul_start = 1'b0;
    tick(1);
    chk("ign_done_t6", 32'(A_mul_done), 32'd1);
    go(2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);

    // Reset during PP2 discards the operation.
    issue(2'b11, 32'd5, 32'hFFFF_FFF9, 32'd0, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("prst_src1", A_mul_src1, 32'd0);
    chk("prst_src2", A_mul_src2, 32'd0);
    chk("prst_busy", 32'(A_mul_busy), 32'd0);
    chk("prst_done", 32'(A_mul_done), 32'd0);
    chk("prst_result", A_mul_result, 32'd0);
    tick(8);
    chk("prst_result_hold", A_mul_result, 32'd0);
    chk("prst_busy_hold", 32'(A_mul_busy), 32'd0);

    go(2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060);
    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      go(rop, ra, rb, ref_mul(rop, ra, rb));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
